// File: rtl/avalon_shared_byte_ram.sv
// Byte RAM shared by the CPU data (r/w) and instruction (r/o) Avalon-MM ports.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate the conflict winner.
module avalon_shared_byte_ram #(
  parameter int    ADDR_WIDTH  = 14,
  parameter string INIT_FILE   = "",
  parameter int    COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  avs_main_address,
  input  logic                   avs_main_byteenable,
  input  logic                   avs_main_read,
  output logic [7:0]             avs_main_readdata,
  input  logic                   avs_main_write,
  input  logic [7:0]             avs_main_writedata,
  output logic                   avs_main_waitrequest,
  output logic                   avs_main_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]  avs_instr_address,
  input  logic                   avs_instr_read,
  output logic [7:0]             avs_instr_readdata,
  output logic                   avs_instr_waitrequest,
  output logic                   avs_instr_readdatavalid,
  output logic [COUNT_WIDTH-1:0] conflict_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  logic main_req, instr_req, both_req;
  logic instr_wins;
  logic main_wait, instr_wait;
  logic main_acc, instr_acc;
  logic main_rd, main_wr;

  logic [7:0]             main_rdata_d, main_rdata_q;
  logic                   main_rvalid_d, main_rvalid_q;
  logic [7:0]             instr_rdata_d, instr_rdata_q;
  logic                   instr_rvalid_d, instr_rvalid_q;
  logic [COUNT_WIDTH-1:0] count_d, count_q;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic { WIN_MAIN = 1'b0, WIN_INSTR = 1'b1 } winner_e;
  winner_e last_winner_d, last_winner_q;
`endif

  // Arbitration: decide which port may touch the array this cycle.
  always_comb begin
    main_req  = avs_main_read | avs_main_write;
    instr_req = avs_instr_read;
    both_req  = main_req & instr_req;
`ifdef ARB_ROUND_ROBIN_EN
    instr_wins = (last_winner_q == WIN_MAIN);
`else
    instr_wins = 1'b0;
`endif
    main_wait  = reset | (both_req & instr_wins);
    instr_wait = reset | (both_req & ~instr_wins);
    main_acc   = main_req & ~main_wait;
    instr_acc  = instr_req & ~instr_wait;
    // read+write together behaves as a plain write
    main_rd    = main_acc & ~avs_main_write;
    main_wr    = main_acc & avs_main_write & avs_main_byteenable;
  end

  // Next-state for read responses, conflict counter and winner history.
  always_comb begin
    main_rdata_d   = main_rd ? mem[avs_main_address] : main_rdata_q;
    main_rvalid_d  = main_rd;
    instr_rdata_d  = instr_acc ? mem[avs_instr_address] : instr_rdata_q;
    instr_rvalid_d = instr_acc;
    count_d        = count_q + COUNT_WIDTH'(both_req);
`ifdef ARB_ROUND_ROBIN_EN
    last_winner_d  = last_winner_q;
    if (both_req) last_winner_d = instr_wins ? WIN_INSTR : WIN_MAIN;
`endif
  end

  // Response and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      main_rdata_q   <= '0;
      main_rvalid_q  <= 1'b0;
      instr_rdata_q  <= '0;
      instr_rvalid_q <= 1'b0;
      count_q        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q  <= WIN_MAIN;
`endif
    end else begin
      main_rdata_q   <= main_rdata_d;
      main_rvalid_q  <= main_rvalid_d;
      instr_rdata_q  <= instr_rdata_d;
      instr_rvalid_q <= instr_rvalid_d;
      count_q        <= count_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q  <= last_winner_d;
`endif
    end
  end

  // Array write; contents survive reset.
  always_ff @(posedge clock) begin
    if (main_wr) mem[avs_main_address] <= avs_main_writedata;
  end

  assign avs_main_waitrequest    = main_wait;
  assign avs_instr_waitrequest   = instr_wait;
  assign avs_main_readdata       = main_rdata_q;
  assign avs_main_readdatavalid  = main_rvalid_q;
  assign avs_instr_readdata      = instr_rdata_q;
  assign avs_instr_readdatavalid = instr_rvalid_q;
  assign conflict_count          = count_q;

endmodule

// File: tb/tb_avalon_shared_byte_ram.sv
// Bench for avalon_shared_byte_ram: behavioural model plus directed vectors.
// Honours ARB_ROUND_ROBIN_EN when the build defines it.
module tb_avalon_shared_byte_ram;

  localparam int AW = 14;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m_addr;
  logic          m_be, m_rd, m_wr;
  logic [7:0]    m_wd;
  logic [7:0]    m_rdata;
  logic          m_wait, m_valid;
  logic [AW-1:0] i_addr;
  logic          i_rd;
  logic [7:0]    i_rdata;
  logic          i_wait, i_valid;
  logic [CW-1:0] cnt;

  int vec = 0;
  int errs = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  avalon_shared_byte_ram #(
    .ADDR_WIDTH (AW),
    .INIT_FILE  (""),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock                  (clk),
    .reset                  (reset),
    .avs_main_address       (m_addr),
    .avs_main_byteenable    (m_be),
    .avs_main_read          (m_rd),
    .avs_main_readdata      (m_rdata),
    .avs_main_write         (m_wr),
    .avs_main_writedata     (m_wd),
    .avs_main_waitrequest   (m_wait),
    .avs_main_readdatavalid (m_valid),
    .avs_instr_address      (i_addr),
    .avs_instr_read         (i_rd),
    .avs_instr_readdata     (i_rdata),
    .avs_instr_waitrequest  (i_wait),
    .avs_instr_readdatavalid(i_valid),
    .conflict_count         (cnt)
  );

  // model state
  logic [7:0]    mm [int];
  logic          e_mv, e_iv;
  logic [7:0]    e_md, e_id;
  logic [CW-1:0] e_cnt;
  bit            instr_last;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // who wins a conflict right now
  function automatic bit instr_takes_conflict();
`ifdef ARB_ROUND_ROBIN_EN
    return !instr_last;
`else
    return 1'b0;
`endif
  endfunction

  // model advance at each active edge
  always @(posedge clk) begin
    bit mq, iq, mw, iw;
    if (reset) begin
      e_mv = 0; e_iv = 0; e_md = 0; e_id = 0; e_cnt = 0; instr_last = 0;
    end else begin
      mq = m_rd | m_wr;
      iq = i_rd;
      iw = iq && (!mq || instr_takes_conflict());
      mw = mq && !(iq && instr_takes_conflict());
      e_mv = 0;
      e_iv = 0;
      if (mw) begin
        if (m_wr) begin
          if (m_be) mm[int'(m_addr)] = m_wd;
        end else begin
          e_mv = 1;
          e_md = mm[int'(m_addr)];
        end
      end
      if (iw) begin
        e_iv = 1;
        e_id = mm[int'(i_addr)];
      end
      if (mq && iq) begin
        e_cnt = e_cnt + 1;
        instr_last = iw;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    bit mq, iq, ewm, ewi;
    if (chk) begin
      mq = m_rd | m_wr;
      iq = i_rd;
      ewm = reset || (mq && iq && instr_takes_conflict());
      ewi = reset || (mq && iq && !instr_takes_conflict());
      cmp("main_wait", 32'(m_wait), 32'(ewm));
      cmp("instr_wait", 32'(i_wait), 32'(ewi));
      cmp("main_valid", 32'(m_valid), 32'(e_mv));
      cmp("instr_valid", 32'(i_valid), 32'(e_iv));
      cmp("main_rdata", 32'(m_rdata), 32'(e_md));
      cmp("instr_rdata", 32'(i_rdata), 32'(e_id));
      cmp("count", cnt, e_cnt);
    end
  end

  task automatic drive(input bit rst, input bit mr, input bit mwr,
                       input int ma, input logic [7:0] wd, input bit be,
                       input bit ir, input int ia);
    reset = rst; m_rd = mr; m_wr = mwr; m_addr = AW'(ma);
    m_wd = wd; m_be = be; i_rd = ir; i_addr = AW'(ia);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  logic [7:0] burst [4] = '{8'h13, 8'h00, 8'h00, 8'h00};

  initial begin
    drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
    step();
    chk = 1'b1;
    step();
    cmp("reset_count", cnt, 32'd0);
    cmp("reset_mvalid", 32'(m_valid), 32'd0);
    cmp("reset_rdata", 32'(m_rdata), 32'd0);

    // preload instruction bytes through the data port
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, k, burst[k], 1, 0, 0);
      step();
    end

    // uncontended write then read
    drive(0, 0, 1, 'h10, 8'hA5, 1, 0, 0);
    #1 cmp("wr_wait", 32'(m_wait), 32'd0);
    step();
    drive(0, 1, 0, 'h10, 8'h00, 0, 0, 0);
    step();
    idle();
    cmp("rd_valid", 32'(m_valid), 32'd1);
    cmp("rd_data", 32'(m_rdata), 32'hA5);
    step();
    cmp("rd_valid_once", 32'(m_valid), 32'd0);
    cmp("rd_hold", 32'(m_rdata), 32'hA5);

    // masked write is ignored
    drive(0, 0, 1, 'h10, 8'hFF, 0, 0, 0);
    step();
    drive(0, 1, 0, 'h10, 8'h00, 0, 0, 0);
    step();
    idle();
    cmp("be0_data", 32'(m_rdata), 32'hA5);
    step();

    // instruction burst
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 8'h00, 0, 1, k);
      step();
      cmp("burst_valid", 32'(i_valid), 32'd1);
      cmp("burst_data", 32'(i_rdata), 32'(burst[k]));
    end
    idle();
    step();
    cmp("burst_end", 32'(i_valid), 32'd0);

    // three conflict cycles, then instr alone
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 'h10, 8'h00, 0, 1, 0);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      cmp("rr_iwait", 32'(i_wait), (k == 1) ? 32'd1 : 32'd0);
      cmp("rr_mwait", 32'(m_wait), (k == 1) ? 32'd0 : 32'd1);
`else
      cmp("fx_iwait", 32'(i_wait), 32'd1);
      cmp("fx_mwait", 32'(m_wait), 32'd0);
`endif
      step();
    end
    cmp("conflict3", cnt, 32'd3);
    drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
    #1 cmp("instr_alone_wait", 32'(i_wait), 32'd0);
    step();
    idle();
    cmp("instr_alone_valid", 32'(i_valid), 32'd1);
    cmp("instr_alone_data", 32'(i_rdata), 32'h13);
    step();

    // read+write together acts as write only
    drive(0, 1, 1, 'h20, 8'h5A, 1, 0, 0);
    step();
    idle();
    cmp("rw_novalid", 32'(m_valid), 32'd0);
    drive(0, 1, 0, 'h20, 8'h00, 0, 0, 0);
    step();
    idle();
    cmp("rw_data", 32'(m_rdata), 32'h5A);
    step();

    // reset in the middle of traffic
    drive(0, 1, 0, 'h10, 8'h00, 0, 0, 0);
    step();
    drive(1, 1, 0, 'h10, 8'h00, 0, 1, 0);
    #1;
    cmp("rst_mwait", 32'(m_wait), 32'd1);
    cmp("rst_iwait", 32'(i_wait), 32'd1);
    cmp("rst_inflight", 32'(m_valid), 32'd1);
    step();
    idle();
    cmp("post_rst_count", cnt, 32'd0);
    cmp("post_rst_mvalid", 32'(m_valid), 32'd0);
    cmp("post_rst_ivalid", 32'(i_valid), 32'd0);
    step();
    cmp("post_rst_mvalid2", 32'(m_valid), 32'd0);
    drive(0, 1, 0, 'h10, 8'h00, 0, 0, 0);
    step();
    idle();
    cmp("kept_data", 32'(m_rdata), 32'hA5);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
